// File: rtl/int2fp_norm_round.sv
// int2fp_norm_round
//   Converts a 32-bit integer (signed or unsigned) to an IEEE-754 binary32
//   value with rounding, in a two-stage valid/ready pipeline.
//     S1: sign, absolute magnitude, leading-zero count, zero flag, rounding mode
//     S2: normalise, round, pack result and inexact flag
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operand valid
//   in_ready    operand accepted this cycle (never depends on in_valid)
//   in_data     integer operand
//   in_signed   1 = two's complement, 0 = unsigned
//   in_rm       rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 RNE
//   flush       synchronous kill of both pipeline stages
//   out_valid   result valid
//   out_ready   consumer accepts the result
//   out_result  binary32 result
//   out_nx      inexact flag for out_result

module int2fp_norm_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  input  logic [2:0]  in_rm,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_nx
);

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  // Reserved encodings collapse to RNE so S2 only ever sees the five modes.
  function automatic rm_e decode_rm(input logic [2:0] rm);
    case (rm)
      3'd1:    decode_rm = RM_RTZ;
      3'd2:    decode_rm = RM_RDN;
      3'd3:    decode_rm = RM_RUP;
      3'd4:    decode_rm = RM_RMM;
      default: decode_rm = RM_RNE;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid, s2_valid;
  logic s2_adv, s1_adv, accept;

  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid & s1_adv & ~flush;

  // ---------------------------------------------------------------------------
  // S1 input analysis
  // ---------------------------------------------------------------------------
  logic        in_sign;
  logic [31:0] in_mag;
  logic [4:0]  in_lz;

  assign in_sign = in_signed & in_data[31];
  // Negating 0x80000000 wraps back to 0x80000000, which is the wanted magnitude.
  assign in_mag  = in_sign ? (~in_data + 32'd1) : in_data;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that leaves it unassigned would infer a latch.
  always_comb begin
    in_lz = 5'd0;
    // Scanning upward lets the highest set bit overwrite the lower ones.
    for (int i = 0; i < 32; i++) begin
      if (in_mag[i]) in_lz = 5'(31 - i);
    end
  end

  logic        s1_sign;
  logic [31:0] s1_mag;
  logic [4:0]  s1_lz;
  logic        s1_zero;
  rm_e         s1_rm;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= 32'd0;
      s1_lz    <= 5'd0;
      s1_zero  <= 1'b0;
      s1_rm    <= RM_RNE;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= in_valid;
      if (accept) begin
        s1_sign <= in_sign;
        s1_mag  <= in_mag;
        s1_lz   <= in_lz;
        s1_zero <= (in_mag == 32'd0);
        s1_rm   <= decode_rm(in_rm);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2 normalise and round
  // ---------------------------------------------------------------------------
  logic [31:0] norm;
  logic [23:0] mant;
  logic        guard, sticky, lsb, inc;
  logic [24:0] mant_sum;
  logic [23:0] mant_r;
  logic [7:0]  exp_r;
  logic [31:0] result_c;
  logic        nx_c;

  assign norm   = s1_mag << s1_lz;
  assign mant   = norm[31:8];
  assign guard  = norm[7];
  assign sticky = |norm[6:0];
  assign lsb    = mant[0];

  always_comb begin
    inc = 1'b0;
    case (s1_rm)
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sign & (guard | sticky);
      RM_RUP:  inc = ~s1_sign & (guard | sticky);
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | lsb);
    endcase
  end

  assign mant_sum = {1'b0, mant} + {24'd0, inc};
  assign mant_r   = mant_sum[24] ? 24'h800000 : mant_sum[23:0];
  // The biased exponent is 158 - lz for a normalised mantissa. Writing it as
  // 157 - lz plus the hidden bit plus the rounding carry folds the carry-out
  // bump into the same adder; the hidden bit is always 1 for non-zero input.
  assign exp_r    = 8'd157 - {3'd0, s1_lz} + {7'd0, mant_r[23]} + {7'd0, mant_sum[24]};

  assign result_c = s1_zero ? 32'd0 : {s1_sign, exp_r, mant_r[22:0]};
  assign nx_c     = ~s1_zero & (guard | sticky);

  logic [31:0] s2_result;
  logic        s2_nx;

  // NOTE: the result registers are reset too, because the outputs must read
  // zero while rst_n is low; pure datapath registers would not otherwise need it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= 32'd0;
      s2_nx     <= 1'b0;
    end else begin
      if (flush)       s2_valid <= 1'b0;
      else if (s2_adv) s2_valid <= s1_valid;
      // Loading only on advance keeps the result stable under backpressure.
      if (s2_adv && s1_valid) begin
        s2_result <= result_c;
        s2_nx     <= nx_c;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_nx     = s2_nx;

endmodule

// File: doc/int2fp_norm_round.md
INT2FP_NORM_ROUND -- requirements
Module: int2fp_norm_round

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at a 32-bit integer in and an IEEE-754 binary32 out.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port in_valid, input, 1: operand valid.
REQ-005 Port in_ready, output, 1: the block accepts the operand this cycle.
REQ-006 Port in_data, input, 32: integer operand.
REQ-007 Port in_signed, input, 1: 1 = two's-complement (FCVT.S.W); 0 = unsigned (FCVT.S.WU).
REQ-008 Port in_rm, input, 3: resolved rounding mode.
  - 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
  - 101–111 SHALL be treated as RNE.
REQ-009 Port flush, input, 1: synchronous pipeline kill.
REQ-010 Port out_valid, output, 1: result valid.
REQ-011 Port out_ready, input, 1: the consumer accepts the result.
REQ-012 Port out_result, output, 32: binary32 result.
REQ-013 Port out_nx, output, 1: inexact flag for out_result.

Function
REQ-014 Pipeline SHALL be two register stages, S1 and S2, each with its own valid bit.
  - Transfer on a port occurs when valid and ready are both 1.
  - With out_ready held 1, out_valid SHALL assert exactly 2 cycles after the accepting edge.
REQ-015 S1 SHALL register three values from the accepted operand.
  - Sign: in_signed & in_data[31].
  - Magnitude: the 32-bit absolute value, with 0x80000000 signed giving magnitude 0x80000000.
  - lz: the 5-bit leading-zero count of the magnitude, plus a zero flag; the rounding mode also travels with the operand.
REQ-016 S2 SHALL compute and register the result.
  - Normalise: magnitude << lz.
  - Mantissa: keep bits [31:8] (24 bits); guard = bit 7; sticky = OR of bits [6:0].
  - Exponent: 158 − lz.
REQ-017 Rounding SHALL increment the 24-bit mantissa as follows:
  - RNE: guard & (sticky | lsb).
  - RTZ: never.
  - RDN: sign & (guard | sticky).
  - RUP: ~sign & (guard | sticky).
  - RMM: guard.
REQ-018 Mantissa carry-out SHALL set the mantissa to 0x800000 and increment the exponent by 1; overflow past 2^32 cannot occur.
REQ-019 out_result SHALL be {sign, exponent[7:0], mantissa[22:0]}; out_nx SHALL be guard | sticky.
REQ-020 A zero operand SHALL give out_result 0x00000000 and out_nx 0 under all rounding modes.
REQ-021 Handshake rules:
  - S2 advances when ~s2_valid | out_ready.
  - S1 advances when ~s1_valid | S2 advancing.
  - in_ready SHALL be 1 exactly when S1 can load.
  - Back-to-back throughput SHALL be 1 operation per cycle.
REQ-022 While out_valid=1 and out_ready=0, out_result and out_nx SHALL hold stable, and no operand SHALL be dropped or reordered.
REQ-023 in_ready SHALL not depend combinationally on in_valid.
REQ-024 flush=1 SHALL clear both valid bits at the edge.
  - No operand is accepted in the flush cycle, even if in_valid & in_ready.
  - in_ready MAY be 1 during flush.
REQ-025 flush and out_ready asserted in the same cycle SHALL still complete the transfer of the current out_result on that edge.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, clear the S1 and S2 valid bits, so out_valid=0 and in_ready=1.
REQ-027 While rst_n=0, out_result and out_nx SHALL read 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operands; the first accept after rst_n rises SHALL produce out_valid 2 cycles later.

Verification
REQ-029 Basic conversions, each -> out_valid exactly 2 cycles after accept:
  - 0x00000001 signed, RNE -> 0x3F800000, nx 0.
  - 0xFFFFFFFF signed, RDN -> 0xBF800000, nx 0.
REQ-030 Most-negative and largest-unsigned operands:
  - 0x80000000 signed -> 0xCF000000, nx 0.
  - 0x80000000 unsigned -> 0x4F000000, nx 0.
  - 0xFFFFFFFF unsigned, RNE -> 0x4F800000, nx 1 (exponent-carry path).
REQ-031 Rounding modes:
  - 0x7FFFFFFF signed: RNE -> 0x4F000000, nx 1; RTZ -> 0x4EFFFFFF, nx 1.
  - 0x01000001 unsigned (tie): RNE -> 0x4B800000, nx 1; RUP -> 0x4B800001, nx 1; RMM -> 0x4B800001, nx 1.
REQ-032 Backpressure: 4 operands offered back-to-back with out_ready=0:
  - The first two are accepted, then in_ready=0.
  - Raising out_ready drains all 4 results in order with no gaps and no loss.
REQ-033 Zero, flush and reset:
  - 0x00000000 under every rm -> 0x00000000, nx 0.
  - flush with 2 operands in flight -> out_valid=0 the next cycle, and neither result ever appears.
  - rst_n pulsed low mid-stream -> out_valid drops without a clock edge.
